// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED blink scheduler.
package led_sched_pkg;

  // Width of each requester's blink count and of the remaining-blink counter.
  localparam int unsigned COUNT_W = 4;

  // Scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Clock cycles per blink phase. Callers must keep the result at 2 or more.
  function automatic int unsigned calc_div(input int unsigned clock_rate_hz,
                                           input int unsigned tick_hz);
    return clock_rate_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Integer clock divider: counts 0..DIV-1, wraps, and raises tick_o for one
// cycle when the count sits at DIV-1. clr_i restarts the count from 0 so a
// freshly granted burst gets a full-length first phase.
module led_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(DIV - 1));

  // Next count: clear on request, wrap on tick, otherwise increment.
  always_comb begin
    // NOTE: assigning a default first means every path drives cnt_d, so no latch is inferred.
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef FORMAL
  a_cnt_below_div: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q < CNT_W'(DIV));
`endif

endmodule

// File: rtl/led_blink_sched.sv
// Status-LED scheduler: arbitrates NREQ requesters, acknowledges the winner
// for one cycle, plays its burst of blinks at the tick rate, then holds the
// LED off for GAP_TICKS ticks before the next grant.
// Build option: define LEDSCHED_RR_EN for round-robin arbitration; the
// default build uses fixed priority (lowest index wins).
module led_blink_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned CLOCK_RATE_HZ = 100_000_000,
  parameter int unsigned TICK_HZ       = 10,
  parameter int unsigned NREQ          = 4,
  parameter int unsigned GAP_TICKS     = 5
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [COUNT_W*NREQ-1:0] i_count,
  output logic [NREQ-1:0]         o_ack,
  output logic [2:0]              o_grant_id,
  output logic                    o_busy,
  output logic                    o_led
);

  localparam int unsigned DIV   = calc_div(CLOCK_RATE_HZ, TICK_HZ);
  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [2:0]           gid_q, gid_d;
  logic                 led_q, led_d;

  logic                 tick;
  logic                 grant;
  logic                 any_req;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     start;
  logic [COUNT_W-1:0]   cnt_arr [NREQ];

  // Split the packed count bus into one nibble per requester.
  for (genvar k = 0; k < NREQ; k++) begin : g_cnt
    assign cnt_arr[k] = i_count[k*COUNT_W +: COUNT_W];
  end

`ifdef LEDSCHED_RR_EN
  logic [IDX_W-1:0] last_q, last_d;

  // Search begins just after the last winner, wrapping at NREQ.
  assign start = (last_q == IDX_W'(NREQ - 1)) ? '0 : last_q + IDX_W'(1);
`else
  assign start = '0;
`endif

  // Pick the first requester at or after 'start', wrapping once around.
  always_comb begin
    logic [IDX_W:0] idx;
    any_req = 1'b0;
    win     = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, start} + (IDX_W + 1)'(i);
      if (idx >= (IDX_W + 1)'(NREQ)) begin
        idx = idx - (IDX_W + 1)'(NREQ);
      end
      if (!any_req && i_req[idx[IDX_W-1:0]]) begin
        any_req = 1'b1;
        win     = idx[IDX_W-1:0];
      end
    end
  end

  led_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .clr_i  (grant),
    .tick_o (tick)
  );

  // Scheduler next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    ack_d   = '0;
    gid_d   = gid_q;
    led_d   = led_q;
    grant   = 1'b0;
`ifdef LEDSCHED_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant      = 1'b1;
          ack_d[win] = 1'b1;
          gid_d      = 3'(win);
`ifdef LEDSCHED_RR_EN
          last_d     = win;
`endif
          // A zero count is acknowledged but plays nothing; stay idle.
          if (cnt_arr[win] == '0) begin
            rem_d = '0;
          end else begin
            rem_d   = cnt_arr[win] - COUNT_W'(1);
            led_d   = 1'b1;
            state_d = ST_ON;
          end
        end
      end
      ST_ON: begin
        if (tick) begin
          led_d   = 1'b0;
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (tick) begin
          if (rem_q == '0) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            rem_d   = rem_q - COUNT_W'(1);
            led_d   = 1'b1;
            state_d = ST_ON;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler registers; reset aborts any burst in progress.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      gid_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      led_q   <= led_d;
    end
  end

`ifdef LEDSCHED_RR_EN
  // Last-grant pointer starts at NREQ-1 so the first search begins at 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_q <= IDX_W'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign o_ack      = ack_q;
  assign o_grant_id = gid_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_led      = led_q;

`ifdef FORMAL
  a_rem_no_underflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (state_q == ST_OFF && tick && rem_q == '0) |=> (state_q == ST_GAP));
  a_ack_onehot0: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $onehot0(ack_q));
`endif

endmodule

// File: tb/tb_led_blink_sched.sv
// Directed bench for led_blink_sched with DIV=10, NREQ=4, GAP_TICKS=2.
// Stimulus and sampling both happen on the falling clock edge.
module tb_led_blink_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] cnt;
  logic [3:0]  ack;
  logic [2:0]  gid;
  logic        busy;
  logic        led;

  int total = 0;
  int bad   = 0;

  led_blink_sched #(
    .CLOCK_RATE_HZ (100),
    .TICK_HZ       (10),
    .NREQ          (4),
    .GAP_TICKS     (2)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req      (req),
    .i_count    (cnt),
    .o_ack      (ack),
    .o_grant_id (gid),
    .o_busy     (busy),
    .o_led      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LED level k cycles after the grant edge for an n-blink burst.
  function automatic logic exp_led(input int k, input int n);
    return (k < 20 * n) && ((k / 10) % 2 == 0);
  endfunction

  // First set bit searching from last+1, wrapping (last=3 gives lowest index).
  function automatic logic [3:0] pick(input logic [3:0] r, input int last);
    logic [3:0] p;
    p = '0;
    for (int i = 1; i <= 4; i++) begin
      int j;
      j = (last + i) % 4;
      if (r[j] && p == '0) p[j] = 1'b1;
    end
    return p;
  endfunction

  function automatic int idx_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return 0;
  endfunction

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!busy && ack == '0) begin ok = 1; break; end
    end
    @(negedge clk);
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_idle: busy still %b after 600 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; cnt = '0;
    @(negedge clk);
    total++; if (led !== 1'b0)   begin bad++; $display("FAIL reset_led: got %b want 0", led); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (ack !== 4'b0)   begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    total++; if (gid !== 3'd0)   begin bad++; $display("FAIL reset_gid: got %0d want 0", gid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int errs;
    req = 4'b0001; cnt = 16'h0003;
    @(negedge clk);
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL single_ack: got %b want 0001", ack); end
    total++; if (gid !== 3'd0)    begin bad++; $display("FAIL single_gid: got %0d want 0", gid); end
    req = '0;
    errs = 0;
    for (int k = 0; k <= 80; k++) begin
      if (k > 0) @(negedge clk);
      if (led !== exp_led(k, 3)) errs++;
      if (k == 1) begin
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL single_ack_len: got %b want 0000", ack); end
      end
      if (k == 79) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy79: got %b want 1", busy); end
      end
      if (k == 80) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy80: got %b want 0", busy); end
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL single_led_pattern: %0d wrong cycles, want 0", errs); end
    wait_idle();
  endtask

  task automatic test_simultaneous();
    int when;
    req = 4'b1010; cnt = 16'h2010;
    @(negedge clk);
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL simul_first: got %b want 0010", ack); end
    req = 4'b1000;
    when = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ack != '0) begin when = k; break; end
    end
    // Burst of 1 (20) + gap (20) ends at edge 40; IDLE grants on the next edge.
    total++; if (when != 41)     begin bad++; $display("FAIL simul_second_time: got %0d want 41", when); end
    total++; if (ack !== 4'b1000) begin bad++; $display("FAIL simul_second_ack: got %b want 1000", ack); end
    req = '0;
    @(negedge clk);
    total++; if (ack !== 4'b0)   begin bad++; $display("FAIL simul_ack_len: got %b want 0000", ack); end
    total++; if (led !== 1'b1)   begin bad++; $display("FAIL simul_led: got %b want 1", led); end
    wait_idle();
  endtask

  task automatic test_zero_count();
    req = 4'b0100; cnt = 16'h0000;
    @(negedge clk);
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL zero_ack: got %b want 0100", ack); end
    total++; if (gid !== 3'd2)    begin bad++; $display("FAIL zero_gid: got %0d want 2", gid); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
    req = '0;
    @(negedge clk);
    total++; if (ack !== 4'b0)    begin bad++; $display("FAIL zero_ack_len: got %b want 0000", ack); end
    total++; if (led !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL zero_idle: led=%b busy=%b want 0 0", led, busy); end
  endtask

  task automatic test_reset_mid_burst();
    int errs;
    req = 4'b0001; cnt = 16'h0004;
    @(negedge clk);
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL rst_first_ack: got %b want 0001", ack); end
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (led !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL rst_async: led=%b busy=%b want 0 0", led, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL rst_reack: got %b want 0001", ack); end
    req = '0;
    errs = 0;
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) @(negedge clk);
      if (led !== exp_led(k, 4)) errs++;
      if (k == 99) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy99: got %b want 1", busy); end
      end
      if (k == 100) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy100: got %b want 0", busy); end
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL rst_led_pattern: %0d wrong cycles, want 0", errs); end
    wait_idle();
  endtask

  task automatic test_grant_order();
    logic [3:0] order [6];
    bit got;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
    req = 4'b1111; cnt = 16'h1111;
    for (int g = 0; g < 6; g++) begin
      got = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (ack != '0) begin got = 1; break; end
      end
      total++;
      if (!got || ack !== order[g]) begin
        bad++; $display("FAIL order_%0d: got %b want %b", g, ack, order[g]);
      end
      req = req & ~ack;
      if (g == 3) req = 4'b0101;
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_random();
    logic [3:0] pend, req_prev, expa, nw;
    int last, errs, acks;
    rst_n = 1'b0; req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    last = 3; pend = '0; req_prev = '0; errs = 0; acks = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      total++;
      if (!$onehot0(ack) || (ack & ~req_prev) != '0 || (led && !busy)) begin
        bad++; $display("FAIL rand_invariant@%0d: ack=%b req=%b led=%b busy=%b", c, ack, req_prev, led, busy);
      end
      if (ack != '0) begin
        acks++;
`ifdef LEDSCHED_RR_EN
        expa = pick(req_prev, last);
`else
        expa = pick(req_prev, 3);
`endif
        total++;
        if (ack !== expa || gid !== 3'(idx_of(ack))) begin
          bad++; $display("FAIL rand_arb@%0d: ack=%b gid=%0d want %b", c, ack, gid, expa);
        end
        last = idx_of(ack);
      end
      nw = 4'($urandom) & 4'($urandom) & 4'($urandom) & ~ack;
      pend = (pend & ~ack) | nw;
      req = pend;
      cnt = 16'($urandom) & 16'h3333;
      req_prev = pend;
    end
    total++; if (acks == 0) begin bad++; $display("FAIL rand_activity: got 0 acks, want some"); end
    req = '0;
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; cnt = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_zero_count();
    test_reset_mid_burst();
    test_grant_order();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
